// File: rtl/mux_data_read_n_if.sv
// mux_data_read_n_if
// ------------------
// Groups the read-request and read-return signals of mux_data_read_n.
// The design side uses the slave modport. The requester and testbench side
// uses the master modport.
//
// Parameters : N_SRC  - number of data sources (1..32)
//              DATA_W - width of each source word
// Signals    : i_rd_en      read request strobe
//              i_src_data   packed source words, source s at [s*DATA_W +: DATA_W]
//              i_src_valid  per-source valid
//              i_clr_err    clears the sticky collision flag
//              o_data       registered read word
//              o_data_valid one-cycle completion pulse
//              o_src_idx    index of the captured source (0 on timeout)
//              o_timeout    one-cycle timeout pulse
//              o_busy       request in flight
//              o_collision  sticky multi-source flag
interface mux_data_read_n_if #(
  parameter int N_SRC  = 9,
  parameter int DATA_W = 8
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic                      i_rd_en;
  logic [N_SRC*DATA_W-1:0]   i_src_data;
  logic [N_SRC-1:0]          i_src_valid;
  logic                      i_clr_err;
  logic [DATA_W-1:0]         o_data;
  logic                      o_data_valid;
  logic [IDX_W-1:0]          o_src_idx;
  logic                      o_timeout;
  logic                      o_busy;
  logic                      o_collision;

  modport slave (
    input  i_rd_en, i_src_data, i_src_valid, i_clr_err,
    output o_data, o_data_valid, o_src_idx, o_timeout, o_busy, o_collision
  );

  modport master (
    output i_rd_en, i_src_data, i_src_valid, i_clr_err,
    input  o_data, o_data_valid, o_src_idx, o_timeout, o_busy, o_collision
  );
endinterface

// File: rtl/mux_data_read_n.sv
// mux_data_read_n
// ---------------
// Read-data return path. It serves one request at a time. After a request
// (i_rd_en sampled in IDLE), the block waits for any source valid. It then
// captures the lowest-index valid source into a registered output word. If no
// source answers within TIMEOUT cycles, it returns DEFAULT_DATA with a timeout
// pulse. Every output is a register.
//
// Ports : i_clk  clock, rising edge
//         i_rst  synchronous active-high reset
//         bus    mux_data_read_n_if.slave. Carries the request, the source
//                data/valid inputs and the registered read-return outputs.
//
// Build option: define MUX_COLLISION_DET_EN to build the sticky o_collision
// flag. It is set when more than one source is valid at capture and cleared
// by i_clr_err. A new collision beats a clear in the same cycle. Without the
// macro, o_collision is constant 0 and i_clr_err is ignored.
module mux_data_read_n #(
  parameter int                N_SRC        = 9,
  parameter int                DATA_W       = 8,
  parameter int                TIMEOUT      = 4,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(8'hFF)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mux_data_read_n_if.slave     bus
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                data_valid_reg, data_valid_next;
  logic [IDX_W-1:0]    src_idx_reg, src_idx_next;
  logic                timeout_reg, timeout_next;
  logic                collision_reg;
  logic                capture;

  // Unpack the source bus into one word per source.
  logic [DATA_W-1:0]   src_word [N_SRC];
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_word[gi] = bus.i_src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Fixed-priority select: the lowest set valid index wins.
  logic                any_valid;
  logic [IDX_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   sel_data;

  always_comb begin
    any_valid = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (bus.i_src_valid[s] && !any_valid) begin
        any_valid = 1'b1;
        sel_idx   = IDX_W'(s);
        sel_data  = src_word[s];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      src_idx_reg    <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      src_idx_reg    <= src_idx_next;
      timeout_reg    <= timeout_next;
    end
  end

  // Next-state and next-output logic. A valid source and the final wait
  // cycle can occur together. The capture branch is checked first, so the
  // data wins over the timeout.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    data_next       = data_reg;
    src_idx_next    = src_idx_reg;
    data_valid_next = 1'b0;
    timeout_next    = 1'b0;
    capture         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_rd_en) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end
      end
      ST_WAIT: begin
        if (any_valid) begin
          data_next       = sel_data;
          src_idx_next    = sel_idx;
          data_valid_next = 1'b1;
          capture         = 1'b1;
          state_next      = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          data_next       = DEFAULT_DATA;
          src_idx_next    = '0;
          data_valid_next = 1'b1;
          timeout_next    = 1'b1;
          state_next      = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef MUX_COLLISION_DET_EN
  // More than one bit set <=> clearing the lowest set bit leaves a nonzero
  // value. This avoids a full popcount.
  logic multi_valid;
  assign multi_valid = |(bus.i_src_valid & (bus.i_src_valid - N_SRC'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      collision_reg <= 1'b0;
    end else if (capture && multi_valid) begin
      collision_reg <= 1'b1;
    end else if (bus.i_clr_err) begin
      collision_reg <= 1'b0;
    end
  end
`else
  logic unused_collision_inputs;
  assign unused_collision_inputs = bus.i_clr_err ^ capture;
  assign collision_reg = 1'b0;
`endif

  assign bus.o_data       = data_reg;
  assign bus.o_data_valid = data_valid_reg;
  assign bus.o_src_idx    = src_idx_reg;
  assign bus.o_timeout    = timeout_reg;
  assign bus.o_busy       = (state_reg == ST_WAIT);
  assign bus.o_collision  = collision_reg;
endmodule

// File: doc/mux_data_read_n.md
# mux_data_read_n

Parametrised read-data return path with a registered output and a read handshake. It collects read data from N_SRC peripheral sources (pulse-per-second dividers, pulse generators, main memory) and hands one registered word to the bus/SPI slave per read request. It selects the lowest-index valid source and bounds each request with a timeout that returns a default word. An optional sticky flag records multi-source collisions. It sits between the peripheral register banks and the host read port.

## Interface
- N_SRC, 9: number of data sources, 1..32.
- DATA_W, 8: data width per source.
- TIMEOUT, 4: maximum wait cycles after a request; must be at least 1.
- DEFAULT_DATA, 8'hFF: word returned on timeout; DATA_W bits wide.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rd_en  in  1  read request strobe; sampled only in IDLE.
- i_src_data  in  N_SRC*DATA_W  packed source data; source s occupies bits [s*DATA_W +: DATA_W].
- i_src_valid  in  N_SRC  per-source valid for the current request.
- i_clr_err  in  1  clears o_collision.
- o_data  out  DATA_W  registered read word; holds its value until the next completion.
- o_data_valid  out  1  one-cycle pulse on completion, both normal and timeout.
- o_src_idx  out  $clog2(N_SRC), min 1  index of the captured source; 0 on timeout.
- o_timeout  out  1  one-cycle pulse, coincident with o_data_valid, when a request times out.
- o_busy  out  1  high while the FSM is in WAIT.
- o_collision  out  1  sticky; set when more than one source is valid at capture.

## Operation
- Reset values: o_data=0, o_data_valid=0, o_src_idx=0, o_timeout=0, o_busy=0, o_collision=0, FSM=IDLE, wait counter=0.
- IDLE:
  - i_rd_en=1 → go to WAIT and clear the counter.
  - i_src_valid is ignored in IDLE.
- WAIT, with any i_src_valid bit set:
  - Capture the data of the lowest set index into o_data.
  - o_src_idx = that index; o_data_valid=1 for one cycle.
  - Go to IDLE.
- WAIT, with no valid bit set:
  - Increment the counter.
  - When the counter reaches TIMEOUT-1 and there is still no valid: o_data=DEFAULT_DATA, o_src_idx=0, o_data_valid=1, o_timeout=1, go to IDLE.
- i_rd_en while in WAIT, or in the completion cycle: ignored, not queued.
- A valid bit and the timeout in the same cycle: the valid bit wins and is a normal capture.
- Counter width is $clog2(TIMEOUT+1). The counter never wraps; it is cleared on entry to WAIT.
- Collision (only with the macro defined): set o_collision when a capture sees popcount(i_src_valid) > 1.
  - i_clr_err alone clears it.
  - i_clr_err in the same cycle as a new collision leaves it set (set wins).
- i_rst mid-WAIT → IDLE on the next edge with all outputs at their reset values; no o_data_valid is produced for the aborted request.

## Timing
- i_rd_en high at edge k → o_busy=1 after edge k.
- First sample of i_src_valid is at edge k+1. Valid seen at edge k+j (1 ≤ j ≤ TIMEOUT) → o_data, o_data_valid and o_src_idx update at edge k+j.
- No valid at edges k+1..k+TIMEOUT → timeout completion at edge k+TIMEOUT.
- o_busy drops at the completion edge. The next i_rd_en is accepted at the following edge.
- Minimum request-to-request spacing: 2 cycles.
- Input-to-output combinational paths: none. All outputs are registers.

## Configuration
- MUX_COLLISION_DET_EN defined: the popcount collision check and the sticky o_collision register are built, and i_clr_err is functional.
- MUX_COLLISION_DET_EN undefined: o_collision is tied to 0 and i_clr_err is ignored. Priority selection and all other behaviour are unchanged.

## Test plan
All scenarios use N_SRC=9, DATA_W=8, TIMEOUT=4, DEFAULT_DATA=8'hFF.
- Reset: hold i_rst 2 cycles with src1=52 valid and i_rd_en=1 → every output stays 0 and o_busy stays 0.
- Single source: i_rd_en at edge k, src1=52 valid → o_data=52, o_src_idx=1, o_data_valid pulse at edge k+1, o_busy low after k+1.
- Late source: i_rd_en at edge k, src8=10 valid from edge k+3 → capture at edge k+3, o_data=10, o_src_idx=8, o_timeout=0.
- Timeout: i_rd_en at edge k, no valids → at edge k+4 o_data=8'hFF, o_src_idx=0, o_data_valid=1 and o_timeout=1 for exactly one cycle. A second i_rd_en at edge k+4 is ignored.
- Collision: src2=21 and src3=31 valid → o_data=21, o_src_idx=2, o_collision=1 and it stays set over later clean reads.
  - i_clr_err pulse → o_collision=0.
  - Rebuilt without MUX_COLLISION_DET_EN → o_collision stays 0 throughout.
- Reset mid-operation: i_rst at edge k+2 of a pending request → IDLE, no o_data_valid pulse. A new request after reset completes normally.
